// File: rtl/fetch_arbiter_if.sv
// Bundles the fetcher-side and memory-side read channels of fetch_arbiter.
// master = arbiter side, slave = surrounding fetchers and program memory.
interface fetch_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);
  // Handshake: a requester raises *_read_valid with a stable address and
  // holds it. The responder raises *_read_ready with data. The transfer
  // completes on the first rising edge where both are high. A fetcher
  // releases the slot by dropping valid, after which ready falls.
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;

  modport master (
    input  consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    output consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );

  modport slave (
    output consumer_read_valid, consumer_read_address, mem_read_ready, mem_read_data,
    input  consumer_read_ready, consumer_read_data, mem_read_valid, mem_read_address
  );
endinterface

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among fetchers.
// Define FETCH_ARB_BROADCAST_EN to serve all fetchers waiting on the same address with one read.
module fetch_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic            clk,
  input  logic            reset,
  fetch_arbiter_if.master bus,
  output logic [1:0]      dbg_state
);
  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    READ_WAITING = 2'd1,
    RELAYING     = 2'd2
  } state_t;

  state_t                             state, state_nx;
  logic [IW-1:0]                      last_grant, last_grant_nx;
  logic [NUM_CONSUMERS-1:0]           served, served_nx;
  logic [NUM_CONSUMERS-1:0]           ready_q, ready_nx;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_nx;
  logic                               mvalid_q, mvalid_nx;
  logic [ADDR_BITS-1:0]               maddr_q, maddr_nx;

  logic                               grant_found;
  logic [IW-1:0]                      grant_sel;
  logic [NUM_CONSUMERS-1:0]           hit_set;

  // First requester after last_grant, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = last_grant;
    for (int off = 1; off <= NUM_CONSUMERS; off++) begin
      if (!grant_found &&
          bus.consumer_read_valid[(int'(last_grant) + off) % NUM_CONSUMERS]) begin
        grant_found = 1'b1;
        grant_sel   = IW'((int'(last_grant) + off) % NUM_CONSUMERS);
      end
    end
  end

  // last_grant already names the granted fetcher while a read is in flight.
  always_comb begin
    hit_set             = '0;
    hit_set[last_grant] = 1'b1;
`ifdef FETCH_ARB_BROADCAST_EN
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (bus.consumer_read_valid[i] &&
          bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS] == maddr_q)
        hit_set[i] = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nx      = state;
    last_grant_nx = last_grant;
    served_nx     = served;
    ready_nx      = ready_q;
    data_nx       = data_q;
    mvalid_nx     = mvalid_q;
    maddr_nx      = maddr_q;
    case (state)
      IDLE: begin
        if (grant_found) begin
          last_grant_nx = grant_sel;
          mvalid_nx     = 1'b1;
          maddr_nx      = bus.consumer_read_address[int'(grant_sel)*ADDR_BITS +: ADDR_BITS];
          state_nx      = READ_WAITING;
        end
      end
      READ_WAITING: begin
        if (bus.mem_read_ready) begin
          mvalid_nx = 1'b0;
          served_nx = hit_set;
          ready_nx  = ready_q | hit_set;
          for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (hit_set[i]) data_nx[i*DATA_BITS +: DATA_BITS] = bus.mem_read_data;
          end
          state_nx = RELAYING;
        end
      end
      RELAYING: begin
        // Each served fetcher is released on its own once it drops valid.
        served_nx = served & bus.consumer_read_valid;
        ready_nx  = ready_q & ~(served & ~bus.consumer_read_valid);
        if (served_nx == '0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_CONSUMERS - 1);
      served     <= '0;
      ready_q    <= '0;
      data_q     <= '0;
      mvalid_q   <= 1'b0;
      maddr_q    <= '0;
    end else begin
      state      <= state_nx;
      last_grant <= last_grant_nx;
      served     <= served_nx;
      ready_q    <= ready_nx;
      data_q     <= data_nx;
      mvalid_q   <= mvalid_nx;
      maddr_q    <= maddr_nx;
    end
  end

  assign bus.consumer_read_ready = ready_q;
  assign bus.consumer_read_data  = data_q;
  assign bus.mem_read_valid      = mvalid_q;
  assign bus.mem_read_address    = maddr_q;
  assign dbg_state               = state;
endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: transaction-level model, per-cycle compare, and
// directed scenarios with hand-computed grant orders and addresses.
module tb_fetch_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
`ifdef FETCH_ARB_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  fetch_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  fetch_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [AW-1:0] exp_q[$];
  logic [DW-1:0] mem_word [256];
  int stall = 0;
  int issued[N]     = '{default: 0};
  int served_cnt[N] = '{default: 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- program memory responder ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        bus.mem_read_ready = 1'b0;
        wcnt = 0;
      end else if (bus.mem_read_valid && !bus.mem_read_ready) begin
        if (wcnt >= stall) begin
          bus.mem_read_ready = 1'b1;
          bus.mem_read_data  = mem_word[bus.mem_read_address];
        end else begin
          wcnt++;
        end
      end else begin
        bus.mem_read_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- fetchers: request, capture, release ----------------
  initial begin
    bus.consumer_read_valid = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (bus.consumer_read_valid[i] && bus.consumer_read_ready[i]) begin
          bus.consumer_read_valid[i] = 1'b0;
          served_cnt[i]++;
        end else if (!bus.consumer_read_valid[i] && !bus.consumer_read_ready[i] &&
                     issued[i] > served_cnt[i]) begin
          bus.consumer_read_valid[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- behavioural model ----------------
  int              m_phase;  // 0 no read, 1 memory busy, 2 handing data out
  int              m_last;
  logic [N-1:0]    m_served, m_ready;
  logic [N*DW-1:0] m_data;
  logic            m_mvalid;
  logic [AW-1:0]   m_maddr;
  int              grant_log[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_last = N - 1; m_served = '0; m_ready = '0;
      m_data = '0; m_mvalid = 1'b0; m_maddr = '0;
    end else begin
      case (m_phase)
        0: begin
          int g;
          g = rr_pick(bus.consumer_read_valid, m_last);
          if (g >= 0) begin
            m_last = g;
            m_maddr = bus.consumer_read_address[g*AW +: AW];
            m_mvalid = 1'b1;
            m_phase = 1;
            grant_log.push_back(g);
          end
        end
        1: if (bus.mem_read_ready) begin
          m_mvalid = 1'b0;
          for (int i = 0; i < N; i++) begin
            if (i == m_last || (BCAST && bus.consumer_read_valid[i] &&
                                bus.consumer_read_address[i*AW +: AW] == m_maddr)) begin
              m_served[i] = 1'b1;
              m_ready[i]  = 1'b1;
              m_data[i*DW +: DW] = mem_word[m_maddr];
            end
          end
          m_phase = 2;
        end
        default: begin
          for (int i = 0; i < N; i++) begin
            if (m_served[i] && !bus.consumer_read_valid[i]) begin
              m_served[i] = 1'b0;
              m_ready[i]  = 1'b0;
            end
          end
          if (m_served == '0) m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- compare process + scoreboard of memory requests ----------------
  logic prev_mvalid = 1'b0;
  always @(negedge clk) begin
    cycle++;
    checks++;
    if (bus.mem_read_valid !== m_mvalid || bus.mem_read_address !== m_maddr ||
        bus.consumer_read_ready !== m_ready || bus.consumer_read_data !== m_data) begin
      errors++;
      $display("FAIL cycle_cmp @%0d: valid %0b/%0b addr %0h/%0h ready %b/%b data %h/%h (dut/model)",
               cycle, bus.mem_read_valid, m_mvalid, bus.mem_read_address, m_maddr,
               bus.consumer_read_ready, m_ready, bus.consumer_read_data, m_data);
    end
    if (bus.mem_read_valid && !prev_mvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req_order @%0d: got addr %0h expected no request", cycle, bus.mem_read_address);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (bus.mem_read_address !== e) begin
          errors++;
          $display("FAIL mem_req_order @%0d: got addr %0h expected %0h", cycle, bus.mem_read_address, e);
        end
      end
    end
    prev_mvalid = bus.mem_read_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input int i, input logic [AW-1:0] a);
    bus.consumer_read_address[i*AW +: AW] = a;
    issued[i]++;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < 300) begin
      busy = (bus.consumer_read_valid != '0) || (bus.consumer_read_ready != '0) || bus.mem_read_valid;
      for (int i = 0; i < N; i++) if (issued[i] != served_cnt[i]) busy = 1'b1;
      if (busy) begin @(posedge clk); n++; end
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    @(posedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int g0;
    int rr_exp[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int k = 0; k < 256; k++) mem_word[k] = 16'(k * 257) ^ 16'h3C96;
    mem_word[8'h13] = 16'hA5C3;
    bus.consumer_read_address = '0;

    // reset state
    @(negedge clk);
    chk("reset_mem_valid", 64'(bus.mem_read_valid), 64'h0);
    chk("reset_ready", 64'(bus.consumer_read_ready), 64'h0);
    chk("reset_data", 64'(bus.consumer_read_data), 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // single request: consumer 2 reads 0x13
    g0 = grant_log.size();
    @(posedge clk); #1;
    exp_q.push_back(8'h13);
    start_req(2, 8'h13);
    @(posedge clk); @(negedge clk);
    chk("single_mem_valid", 64'(bus.mem_read_valid), 64'h1);
    chk("single_mem_addr", 64'(bus.mem_read_address), 64'h13);
    chk("single_no_early_ready", 64'(bus.consumer_read_ready), 64'h0);
    @(posedge clk); @(negedge clk);
    chk("single_ready", 64'(bus.consumer_read_ready), 64'b0100);
    chk("single_data", 64'(bus.consumer_read_data[2*DW +: DW]), 64'hA5C3);
    chk("single_mem_valid_drop", 64'(bus.mem_read_valid), 64'h0);
    wait_idle("single");
    chk("single_grant", 64'(grant_log[g0]), 64'd2);

    // round-robin fairness
    do_reset();
    g0 = grant_log.size();
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(8'h10 + rr_exp[k]));
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      start_req(i, 8'(8'h10 + i));
      start_req(i, 8'(8'h10 + i));
    end
    wait_idle("rr");
    chk("rr_all_requests_seen", 64'(exp_q.size()), 64'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("rr_grant_%0d", k), 64'(grant_log[g0 + k]), 64'(rr_exp[k]));

    // memory stall of 5 cycles
    stall = 5;
    exp_q.push_back(8'h22);
    @(posedge clk); #1;
    start_req(1, 8'h22);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_%0d", k), 64'(bus.mem_read_valid), 64'h1);
      chk($sformatf("stall_addr_%0d", k), 64'(bus.mem_read_address), 64'h22);
      chk($sformatf("stall_ready_%0d", k), 64'(bus.consumer_read_ready), 64'h0);
    end
    @(negedge clk);
    chk("stall_ready", 64'(bus.consumer_read_ready), 64'b0010);
    chk("stall_data", 64'(bus.consumer_read_data[DW +: DW]), 64'(mem_word[8'h22]));
    stall = 0;
    wait_idle("stall");

    // shared address: 0,1,3 on 0x40, 2 on 0x41
    do_reset();
    g0 = grant_log.size();
    if (BCAST) begin
      exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    end else begin
      exp_q.push_back(8'h40); exp_q.push_back(8'h40);
      exp_q.push_back(8'h41); exp_q.push_back(8'h40);
    end
    @(posedge clk); #1;
    start_req(0, 8'h40); start_req(1, 8'h40); start_req(2, 8'h41); start_req(3, 8'h40);
    wait_idle("bcast");
    chk("bcast_all_requests_seen", 64'(exp_q.size()), 64'd0);
    chk("bcast_read_count", 64'(grant_log.size() - g0), BCAST ? 64'd2 : 64'd4);
    chk("bcast_grant_0", 64'(grant_log[g0]), 64'd0);
    chk("bcast_grant_1", 64'(grant_log[g0 + 1]), BCAST ? 64'd2 : 64'd1);
    chk("bcast_data", 64'(bus.consumer_read_data),
        {mem_word[8'h40], mem_word[8'h41], mem_word[8'h40], mem_word[8'h40]});

    // asynchronous reset while the memory read is outstanding
    stall = 3;
    exp_q.push_back(8'h30); exp_q.push_back(8'h50); exp_q.push_back(8'h30);
    @(posedge clk); #1;
    start_req(2, 8'h30);
    @(posedge clk); @(negedge clk);
    chk("rst_pre_valid", 64'(bus.mem_read_valid), 64'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.mem_read_valid), 64'h0);
    chk("rst_async_addr", 64'(bus.mem_read_address), 64'h0);
    chk("rst_async_ready", 64'(bus.consumer_read_ready), 64'h0);
    chk("rst_async_data", 64'(bus.consumer_read_data), 64'h0);
    stall = 0;
    start_req(0, 8'h50);
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    g0 = grant_log.size();
    wait_idle("rst");
    chk("rst_all_requests_seen", 64'(exp_q.size()), 64'd0);
    chk("rst_first_grant", 64'(grant_log[g0]), 64'd0);
    chk("rst_second_grant", 64'(grant_log[g0 + 1]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no end by 200000 expected earlier finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
